// File: rtl/star_box_writer.sv
// Raster-scans a clamped bounding box and drives the image RAM write port to draw a star marker.
// Build option STAR_BOX_FILL_EN: defined draws a solid rectangle, undefined draws the outline only.
module star_box_writer #(
    parameter int unsigned xSz          = 6,
    parameter int unsigned ySz          = 6,
    parameter int unsigned addrSz       = 12,
    parameter int unsigned colSz        = 3,
    parameter int unsigned x_resolution = 60,
    parameter int unsigned y_resolution = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [xSz-1:0]    xLeft,
    input  logic [xSz-1:0]    xRight,
    input  logic [ySz-1:0]    yTop,
    input  logic [ySz-1:0]    yBottom,
    input  logic [colSz-1:0]  colour,
    output logic [addrSz-1:0] address,
    output logic [colSz-1:0]  data,
    output logic              wren,
    output logic              busy,
    output logic              done
);

`ifdef STAR_BOX_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    localparam logic [xSz-1:0] X_MAX = xSz'(x_resolution - 1);
    localparam logic [ySz-1:0] Y_MAX = ySz'(y_resolution - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t         state;
    logic [xSz-1:0] x_cur, l_lat, r_lat;
    logic [ySz-1:0] y_cur, t_lat, b_lat;

    logic [xSz-1:0] xl_c, xr_c, l_c, r_c, x_nxt_c;
    logic [ySz-1:0] yt_c, yb_c, t_c, b_c, y_nxt_c;
    logic           row_end_c, last_c, full_row_c;

    // Row-major pixel address y*60 + x built from shifted copies of y.
    function automatic logic [addrSz-1:0] pix_addr(input logic [xSz-1:0] x,
                                                   input logic [ySz-1:0] y);
        logic [addrSz-1:0] ye;
        ye = addrSz'(y);
        return (ye << 5) + (ye << 4) + (ye << 3) + (ye << 2) + addrSz'(x);
    endfunction

    // Clamp incoming coordinates into the image, then order each pair.
    always_comb begin
        xl_c = (xLeft   > X_MAX) ? X_MAX : xLeft;
        xr_c = (xRight  > X_MAX) ? X_MAX : xRight;
        yt_c = (yTop    > Y_MAX) ? Y_MAX : yTop;
        yb_c = (yBottom > Y_MAX) ? Y_MAX : yBottom;
        l_c  = (xl_c > xr_c) ? xr_c : xl_c;
        r_c  = (xl_c > xr_c) ? xl_c : xr_c;
        t_c  = (yt_c > yb_c) ? yb_c : yt_c;
        b_c  = (yt_c > yb_c) ? yt_c : yb_c;
    end

    // Scan stepping: top/bottom rows (or every row when filling) walk L..R, side rows jump L -> R.
    always_comb begin
        row_end_c  = (x_cur == r_lat);
        last_c     = row_end_c && (y_cur == b_lat);
        full_row_c = FILL_EN || (y_cur == t_lat) || (y_cur == b_lat);
        x_nxt_c    = x_cur;
        y_nxt_c    = y_cur;
        if (row_end_c) begin
            x_nxt_c = l_lat;
            y_nxt_c = y_cur + 1'b1;
        end else if (full_row_c) begin
            x_nxt_c = x_cur + 1'b1;
        end else begin
            x_nxt_c = r_lat;
        end
    end

    // Outputs are registered from the position being entered, so address always matches (x_cur, y_cur).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wren    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            address <= '0;
            data    <= '0;
            x_cur   <= '0;
            y_cur   <= '0;
            l_lat   <= '0;
            r_lat   <= '0;
            t_lat   <= '0;
            b_lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        l_lat   <= l_c;
                        r_lat   <= r_c;
                        t_lat   <= t_c;
                        b_lat   <= b_c;
                        x_cur   <= l_c;
                        y_cur   <= t_c;
                        address <= pix_addr(l_c, t_c);
                        data    <= colour;
                        wren    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    if (last_c) begin
                        wren    <= 1'b0;
                        busy    <= 1'b0;
                        address <= '0;
                        data    <= '0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        x_cur   <= x_nxt_c;
                        y_cur   <= y_nxt_c;
                        address <= pix_addr(x_nxt_c, y_nxt_c);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wren    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    address <= '0;
                    data    <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/star_box_writer.md
# star_box_writer

Write-side companion to the star top/bottom search. Given a bounding box (left, right, top, bottom) and a 3-bit colour, it raster-scans the box and drives the write port of the 60x60, 3-bit image RAM (3600 words), marking each detected star with a rectangle outline. It sits between the star-measurement FSMs and the display framebuffer. It accepts one box per start/done handshake.

## Interface
Parameters:
- xSz, 6, x coordinate width
- ySz, 6, y coordinate width
- addrSz, 12, RAM address width
- colSz, 3, pixel colour width
- x_resolution, 60, image width in pixels; last valid x = 59
- y_resolution, 60, image height in pixels; last valid y = 59

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request to draw; sampled only in IDLE
- xLeft  input  xSz  box left column
- xRight  input  xSz  box right column
- yTop  input  ySz  box top row
- yBottom  input  ySz  box bottom row
- colour  input  colSz  pixel value to write
- address  output  addrSz  RAM write address = y*60 + x
- data  output  colSz  RAM write data
- wren  output  1  RAM write enable
- busy  output  1  high while drawing
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: start=1 latches the coordinates and colour, loads xCur=L and yCur=T, and moves to DRAW. Coordinate and colour inputs are don't-care at all other times.
- Latch rules: each coordinate above 59 clamps to 59 first. If L>R after clamping, the two values swap; likewise T>B.
- DRAW, outline mode: wren=1 every cycle. address and data reflect the current (xCur, yCur) and the latched colour.
  - Row T and row B: x steps L..R, one pixel per cycle.
  - Other rows: write x=L, then x=R on the next cycle. If L==R, write a single pixel per row.
  - After the last x of a row, y increments and x reloads to L.
  - If T==B, only one row is drawn.
  - The last write is (R,B); after it, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- Address arithmetic: {y,5'b0}+{y,4'b0}+{y,3'b0}+{y,2'b0}+x, computed at 12 bits unsigned. The maximum is 3599, so there is no overflow.
- Outside DRAW: wren=0, address=0, data=0.

## Timing
- Reset values: state=IDLE, wren=0, busy=0, done=0, address=0, data=0.
- Reset applies at the next rising edge from any state. A draw in progress is abandoned, and no further wren follows the reset edge.
- Latency:
  - The first write is presented in the cycle after the edge that samples start.
  - busy=1 exactly during the DRAW cycles.
  - done is asserted in the cycle after the last write.
  - start may be reasserted in the cycle after done. The earliest back-to-back start is sampled in IDLE, two cycles after the last write.
- Write counts, with w=R−L+1 and h=B−T+1:
  - Outline: w if h=1; otherwise 2w + (h−2)·min(w,2).
  - Fill: w·h.
- The RAM captures address/data/wren on the same rising edge that advances the counters. No read-back is performed.

## Configuration
- Macro: STAR_BOX_FILL_EN.
- Defined: DRAW writes every pixel of every row, L..R, producing a solid rectangle. Cycle count is w·h.
- Undefined: outline-only behaviour as described above.
- Ports and handshake are identical in both builds.

## Test plan
- Reset: hold reset 2 cycles mid-DRAW → next cycle wren=0, busy=0, done=0, address=0, data=0, state IDLE.
- Outline L=2 R=4 T=1 B=3 colour=5: writes addresses 62,63,64,122,124,182,183,184 on consecutive cycles with data=5; busy high 8 cycles; done pulses on the 9th cycle after the start edge.
- Single pixel L=R=10, T=B=20: one write at address 1210, then done the next cycle.
- Clamp and swap L=63 R=57 T=B=0: box becomes 57..59, so writes go to 57,58,59. start pulses during DRAW are ignored, giving exactly one done.
- L=R=0, T=0, B=2, colour=7: writes 0,60,120, then done.
- STAR_BOX_FILL_EN defined, L=2 R=4 T=1 B=3: 9 writes at 62,63,64,122,123,124,182,183,184; done on the 10th cycle.
